pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_if.sv | 34 +++
 rtl/pc_gen.sv | 115 +++++++++++
 tb/tb_pc_gen.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-redirect bus between the pipeline control logic and the PC generator.
//   stall_i       : pipeline stall vector (bit 0 holds the PC)
//   branch_i      : branch redirect request
//   branch_addr_i : branch target
//   flush_i       : exception/trap redirect, highest priority
//   flush_addr_i  : trap vector
//   pc_o          : registered fetch address
//   ce_o          : fetch enable
//   redirect_o    : one-cycle pulse when pc_o was loaded from a redirect
//   pend_o        : a branch captured during a stall is waiting to be applied
interface pc_gen_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned STALL_WIDTH = 6
);
  logic [STALL_WIDTH-1:0] stall_i;
  logic                   branch_i;
  logic [ADDR_WIDTH-1:0]  branch_addr_i;
  logic                   flush_i;
  logic [ADDR_WIDTH-1:0]  flush_addr_i;
  logic [ADDR_WIDTH-1:0]  pc_o;
  logic                   ce_o;
  logic                   redirect_o;
  logic                   pend_o;

  modport master (
    output stall_i, branch_i, branch_addr_i, flush_i, flush_addr_i,
    input  pc_o, ce_o, redirect_o, pend_o
  );

  modport slave (
    input  stall_i, branch_i, branch_addr_i, flush_i, flush_addr_i,
    output pc_o, ce_o, redirect_o, pend_o
  );
endinterface

// File: rtl/pc_gen.sv
// Program counter generator for the fetch stage.
// Produces the sequential fetch address, applies branch and trap redirects, and
// remembers a branch that arrives while the pipeline is stalled so it can be
// applied once the stall releases.
//   clk_i  : clock, all state updates on the rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : pc_gen_if slave modport (stall/branch/flush in, pc/ce/redirect/pend out)
module pc_gen #(
  parameter int unsigned          ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned          INST_BYTES   = 4,
  parameter int unsigned          STALL_WIDTH  = 6
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  pc_gen_if.slave bus
);

  // Value of stall_i[0] that holds the PC.
  localparam logic Stop = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] Inc       = ADDR_WIDTH'(INST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ~(ADDR_WIDTH'(INST_BYTES - 1));
  localparam logic [ADDR_WIDTH-1:0] ResetPc   = RESET_VECTOR & AlignMask;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHoldPend
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  pend_addr_q, pend_addr_d;
  logic                   redirect_q, redirect_d;

  logic [STALL_WIDTH-1:0] stall;
  logic                   stop;
  logic [ADDR_WIDTH-1:0]  branch_tgt;
  logic [ADDR_WIDTH-1:0]  flush_tgt;

  assign stall      = bus.stall_i;
  assign stop       = (stall[0] == Stop);
  assign branch_tgt = bus.branch_addr_i & AlignMask;
  assign flush_tgt  = bus.flush_addr_i & AlignMask;

  // Only bit 0 of the stall vector concerns the PC.
  if (STALL_WIDTH > 1) begin : g_unused_stall
    logic unused_stall;
    assign unused_stall = ^stall[STALL_WIDTH-1:1];
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_addr_d = pend_addr_q;
    redirect_d  = 1'b0;

    case (state_q)
      // Inputs are ignored for the first edge after reset so that the first
      // fetch is the reset vector itself.
      StIdle: state_d = StRun;

      StRun, StHoldPend: begin
        if (bus.flush_i) begin
          pc_d        = flush_tgt;
          pend_addr_d = '0;
          redirect_d  = 1'b1;
          state_d     = StRun;
        end else if (state_q == StHoldPend && !stop) begin
          // Stall released: a same-cycle branch is newer than the pending one.
          pc_d        = bus.branch_i ? branch_tgt : pend_addr_q;
          pend_addr_d = '0;
          redirect_d  = 1'b1;
          state_d     = StRun;
        end else if (bus.branch_i && !stop) begin
          pc_d       = branch_tgt;
          redirect_d = 1'b1;
        end else if (bus.branch_i) begin
          // Stalled: capture the target (latest wins) and hold the PC.
          pend_addr_d = branch_tgt;
          state_d     = StHoldPend;
        end else if (!stop) begin
          pc_d = pc_q + Inc;
        end
      end

      default: begin
        state_d     = StIdle;
        pc_d        = ResetPc;
        pend_addr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      pc_q        <= ResetPc;
      pend_addr_q <= '0;
      redirect_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
      redirect_q  <= redirect_d;
    end
  end

  assign bus.pc_o       = pc_q;
  assign bus.ce_o       = (state_q != StIdle);
  assign bus.redirect_o = redirect_q;
  assign bus.pend_o     = (state_q == StHoldPend);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by randomized
// stimulus, all checked against a rule-level reference model.
module tb_pc_gen;

  localparam int unsigned AW = 32;
  localparam int unsigned SW = 6;

  logic clk;
  logic rst_n;

  pc_gen_if #(.ADDR_WIDTH(AW), .STALL_WIDTH(SW)) bus ();

  pc_gen #(
    .ADDR_WIDTH  (AW),
    .RESET_VECTOR(32'h0),
    .INST_BYTES  (4),
    .STALL_WIDTH (SW)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model state.
  bit          m_running;
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_tgt;
  bit          m_redir;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic model_reset();
    m_running = 1'b0;
    m_pc      = 32'h0;
    m_pend    = 1'b0;
    m_tgt     = 32'h0;
    m_redir   = 1'b0;
  endtask

  // One rising edge worth of behaviour, expressed as the redirect rules.
  task automatic model_edge();
    bit stop;
    stop    = bus.stall_i[0];
    m_redir = 1'b0;
    if (!m_running) begin
      m_running = 1'b1;
    end else if (bus.flush_i) begin
      m_pc = align(bus.flush_addr_i); m_pend = 1'b0; m_redir = 1'b1;
    end else if (bus.branch_i && !stop) begin
      m_pc = align(bus.branch_addr_i); m_pend = 1'b0; m_redir = 1'b1;
    end else if (bus.branch_i) begin
      m_pend = 1'b1; m_tgt = align(bus.branch_addr_i);
    end else if (m_pend && !stop) begin
      m_pc = m_tgt; m_pend = 1'b0; m_redir = 1'b1;
    end else if (!stop) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".pc"},       bus.pc_o,       m_pc);
    check_eq({tag, ".ce"},       bus.ce_o,       m_running);
    check_eq({tag, ".redirect"}, bus.redirect_o, m_redir);
    check_eq({tag, ".pend"},     bus.pend_o,     m_pend);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [SW-1:0] st, input logic br, input logic [31:0] ba,
                       input logic fl, input logic [31:0] fa);
    bus.stall_i       = st;
    bus.branch_i      = br;
    bus.branch_addr_i = ba;
    bus.flush_i       = fl;
    bus.flush_addr_i  = fa;
  endtask

  task automatic idle_inputs();
    drive('0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Assert reset away from the clock edge, check the asynchronous effect, release.
  task automatic pulse_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq({tag, ".rst_pc"}, bus.pc_o, 32'h0);
    check_eq({tag, ".rst_ce"}, bus.ce_o, 1'b0);
    compare_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic flush_to(input logic [31:0] a);
    drive('0, 1'b0, 32'h0, 1'b1, a);
    cycle();
    compare_all("flush_setup");
    idle_inputs();
  endtask

  logic [31:0] seq_exp [4];

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    compare_all("por");
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rel_pc", bus.pc_o, 32'h0);
    check_eq("rel_ce", bus.ce_o, 1'b0);

    // Reset release then free-running fetch.
    seq_exp[0] = 32'h0; seq_exp[1] = 32'h4; seq_exp[2] = 32'h8; seq_exp[3] = 32'hC;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("seq_pc", bus.pc_o, seq_exp[i]);
      check_eq("seq_ce", bus.ce_o, 1'b1);
      compare_all("seq");
    end

    // Stall hold then resume.
    flush_to(32'h10);
    bus.stall_i = 6'b000001;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("stall_pc", bus.pc_o, 32'h10);
      compare_all("stall");
    end
    bus.stall_i = 6'b111110;  // upper bits must not stall
    cycle();
    check_eq("resume_pc", bus.pc_o, 32'h14);
    compare_all("resume");
    idle_inputs();

    // Branch with misaligned target.
    flush_to(32'h20);
    drive('0, 1'b1, 32'h103, 1'b0, 32'h0);
    cycle();
    check_eq("br_pc", bus.pc_o, 32'h100);
    check_eq("br_redir", bus.redirect_o, 1'b1);
    idle_inputs();
    cycle();
    check_eq("br_next_pc", bus.pc_o, 32'h104);
    check_eq("br_next_redir", bus.redirect_o, 1'b0);

    // Pending branch, latest wins.
    flush_to(32'h40);
    drive(6'b000001, 1'b1, 32'h200, 1'b0, 32'h0);
    cycle();
    check_eq("pend1_pc", bus.pc_o, 32'h40);
    check_eq("pend1_pend", bus.pend_o, 1'b1);
    drive(6'b000001, 1'b1, 32'h300, 1'b0, 32'h0);
    cycle();
    check_eq("pend2_pend", bus.pend_o, 1'b1);
    drive(6'b000001, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle();
    compare_all("pend3");
    idle_inputs();
    cycle();
    check_eq("pend_rel_pc", bus.pc_o, 32'h300);
    check_eq("pend_rel_redir", bus.redirect_o, 1'b1);
    check_eq("pend_rel_pend", bus.pend_o, 1'b0);

    // Flush while holding a pending branch discards it.
    flush_to(32'h40);
    drive(6'b000001, 1'b1, 32'h200, 1'b0, 32'h0);
    cycle();
    drive(6'b000001, 1'b0, 32'h0, 1'b1, 32'h80);
    cycle();
    check_eq("fl_pc", bus.pc_o, 32'h80);
    check_eq("fl_pend", bus.pend_o, 1'b0);
    check_eq("fl_redir", bus.redirect_o, 1'b1);
    idle_inputs();
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check_eq("fl_after_pc", bus.pc_o, 32'h80 + 32'(4 * i));
      check_eq("fl_after_redir", bus.redirect_o, 1'b0);
    end

    // Wraparound, then asynchronous reset.
    flush_to(32'hFFFF_FFFC);
    cycle();
    check_eq("wrap_pc", bus.pc_o, 32'h0);
    pulse_reset("async_rst");

    // Reset while holding a pending branch: no redirect after release.
    cycle();
    cycle();
    drive(6'b000001, 1'b1, 32'h500, 1'b0, 32'h0);
    cycle();
    check_eq("hp_pend", bus.pend_o, 1'b1);
    pulse_reset("hp_rst");
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("hp_after_pc", bus.pc_o, 32'(4 * i));
      check_eq("hp_after_redir", bus.redirect_o, 1'b0);
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [SW-1:0] st;
      st      = SW'($urandom);
      st[0]   = ($urandom_range(0, 9) < 4);
      drive(st, ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 11) == 0), $urandom);
      if ($urandom_range(0, 249) == 0) begin
        pulse_reset("rnd_rst");
      end else begin
        cycle();
        compare_all("rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
